wb_arb2: RTL

Two-master Wishbone arbiter that shares one Wishbone slave port between the CPU data master (m0) and instruction master (m1). It sits between the MiniMIPS32 core's dwishbone/iwishbone ports and a single shared slave, such as unified BRAM or a peripheral bridge. It replaces a full crossbar where only one slave path is needed. Round-robin grant is locked per bus cycle (`cyc`), with an optional watchdog that terminates hung transfers with `err`.

---
 rtl/wb_arb2_pkg.sv | 13 +
 rtl/wb_arb2_if.sv | 45 ++++
 rtl/wb_arb2_mux.sv | 54 +++++
 rtl/wb_arb2.sv | 131 +++++++++++++
 4 files changed

// File: rtl/wb_arb2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings and the watchdog counter width.
package wb_arb2_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned WD_W = 16;

endpackage

// File: rtl/wb_arb2_if.sv
// Bus bundle for wb_arb2: both master ports and the shared slave port.
//   slave  modport : arbiter view (master requests and slave responses in,
//                    master terminations and slave requests out)
//   master modport : environment view (the opposite directions)
interface wb_arb2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  localparam int unsigned SW = DW / 8;

  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic [SW-1:0] m0_sel_i,  m1_sel_i;
  logic          m0_we_i,   m1_we_i;
  logic          m0_cyc_i,  m1_cyc_i;
  logic          m0_stb_i,  m1_stb_i;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          m0_ack_o,  m1_ack_o;
  logic          m0_err_o,  m1_err_o;

  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic [DW-1:0] s_data_i;
  logic          s_ack_i;

  modport slave (
    input  m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, m0_sel_i, m1_sel_i,
           m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i,
           s_data_i, s_ack_i,
    output m0_data_o, m1_data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_addr_o, s_data_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

  modport master (
    output m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, m0_sel_i, m1_sel_i,
           m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i,
           s_data_i, s_ack_i,
    input  m0_data_o, m1_data_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_addr_o, s_data_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

endinterface

// File: rtl/wb_arb2_mux.sv
// Combinational owner-select mux for the slave-side request signals.
// Ports: own0/own1 one-hot owner, m0_*/m1_* master requests, s_* outputs.
// With no owner every output is 0.
module wb_arb2_mux #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            own0,
  input  logic            own1,
  input  logic [AW-1:0]   m0_addr,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m0_data,
  input  logic [DW-1:0]   m1_data,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m0_we,
  input  logic            m1_we,
  input  logic            m0_cyc,
  input  logic            m1_cyc,
  input  logic            m0_stb,
  input  logic            m1_stb,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_data,
  output logic [DW/8-1:0] s_sel,
  output logic            s_we,
  output logic            s_cyc,
  output logic            s_stb
);

  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_sel  = '0;
    s_we   = 1'b0;
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    if (own0) begin
      s_addr = m0_addr;
      s_data = m0_data;
      s_sel  = m0_sel;
      s_we   = m0_we;
      s_cyc  = m0_cyc;
      s_stb  = m0_stb;
    end else if (own1) begin
      s_addr = m1_addr;
      s_data = m1_data;
      s_sel  = m1_sel;
      s_we   = m1_we;
      s_cyc  = m1_cyc;
      s_stb  = m1_stb;
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter sharing one slave port between m0 and m1.
// Round-robin grant, locked for the whole bus cycle (owner's cyc high).
// Ports: clk, rstn (async active-low), bus (wb_arb2_if.slave: master and
// slave Wishbone signals), gnt_o (one-hot owner {m1,m0}, 00 when idle).
// Build option: define WB_ARB_TIMEOUT_EN for the stb watchdog that ends a
// hung transfer with err after TIMEOUT_CYC unacknowledged cycles.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rstn,
  wb_arb2_if.slave   bus,
  output logic [1:0] gnt_o
);

  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("wb_arb2: TIMEOUT_CYC must be in 1..65535");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;     // 0: m0 granted most recently, 1: m1
  logic       own0, own1;
  logic       own_cyc, own_active;
  logic       wd_fire;
  logic       mux_cyc, mux_stb;

  assign own0       = (state_q == ARB_OWN0);
  assign own1       = (state_q == ARB_OWN1);
  assign own_cyc    = (own0 & bus.m0_cyc_i) | (own1 & bus.m1_cyc_i);
  assign own_active = (own0 & bus.m0_cyc_i & bus.m0_stb_i) |
                      (own1 & bus.m1_cyc_i & bus.m1_stb_i);

  // State and round-robin history; reset leaves m1 as last so m0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Re-arbitrate whenever nobody holds a bus cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (!own_cyc) begin
      unique case ({bus.m1_cyc_i, bus.m0_cyc_i})
        2'b11: begin
          state_d = last_q ? ARB_OWN0 : ARB_OWN1;
          last_d  = ~last_q;
        end
        2'b01: begin
          state_d = ARB_OWN0;
          last_d  = 1'b0;
        end
        2'b10: begin
          state_d = ARB_OWN1;
          last_d  = 1'b1;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt_q;

  assign wd_fire = own_active & ~bus.s_ack_i & (wd_cnt_q == WD_LAST);

  // Counts consecutive owner stb cycles without ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt_q <= '0;
    end else if (wd_fire || !own_active || bus.s_ack_i || (state_d != state_q)) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  wb_arb2_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .own0    (own0),
    .own1    (own1),
    .m0_addr (bus.m0_addr_i),
    .m1_addr (bus.m1_addr_i),
    .m0_data (bus.m0_data_i),
    .m1_data (bus.m1_data_i),
    .m0_sel  (bus.m0_sel_i),
    .m1_sel  (bus.m1_sel_i),
    .m0_we   (bus.m0_we_i),
    .m1_we   (bus.m1_we_i),
    .m0_cyc  (bus.m0_cyc_i),
    .m1_cyc  (bus.m1_cyc_i),
    .m0_stb  (bus.m0_stb_i),
    .m1_stb  (bus.m1_stb_i),
    .s_addr  (bus.s_addr_o),
    .s_data  (bus.s_data_o),
    .s_sel   (bus.s_sel_o),
    .s_we    (bus.s_we_o),
    .s_cyc   (mux_cyc),
    .s_stb   (mux_stb)
  );

  // Watchdog expiry withdraws the request from the slave for that cycle.
  assign bus.s_cyc_o = mux_cyc & ~wd_fire;
  assign bus.s_stb_o = mux_stb & ~wd_fire;

  assign gnt_o = {own1, own0};

  assign bus.m0_ack_o  = bus.s_ack_i & own0 & bus.m0_stb_i;
  assign bus.m1_ack_o  = bus.s_ack_i & own1 & bus.m1_stb_i;
  assign bus.m0_err_o  = wd_fire & own0;
  assign bus.m1_err_o  = wd_fire & own1;
  assign bus.m0_data_o = bus.s_data_i;
  assign bus.m1_data_o = bus.s_data_i;

endmodule
